// File: rtl/io_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_bridge_pkg
// Description : Shared FSM state encoding and default parameter values for
//               the CPU-to-I/O bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package io_bridge_pkg;

    // Bridge transaction phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } bridge_state_t;

    // Default configuration
    localparam int         c_def_data_w    = 8;
    localparam int         c_def_addr_w    = 8;
    localparam int         c_def_port_aw   = 4;
    localparam logic [7:0] c_def_io_base   = 8'hF0;
    localparam int         c_def_setup_cyc = 1;
    localparam int         c_def_timeout   = 15;

endpackage : io_bridge_pkg
`default_nettype wire

// File: rtl/io_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : io_timeout_counter
// Description : Counts consecutive strobe cycles and flags the cycle in which
//               the LIMIT-th one is reached. load clears the count.
// Revision    : 1.0 - initial release
// ============================================================================
module io_timeout_counter
    import io_bridge_pkg::*;
#(
    parameter int LIMIT = c_def_timeout
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int                 c_cnt_w = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(LIMIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Cycle counter: cleared on load, advances while counting until expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (count && !expire) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Expiry is flagged during the LIMIT-th counted cycle itself
    assign expire = count && (r_cnt == c_last);

endmodule : io_timeout_counter
`default_nettype wire

// File: rtl/io_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_bridge
// Description : Maps a CPU address window onto a strobed bidirectional I/O
//               bus. Each hit runs IDLE -> SETUP -> STROBE -> DONE and ends
//               with a one-cycle cpu_ready pulse.
//               Optional macro IO_BRIDGE_TIMEOUT_EN: abort STROBE after
//               TIMEOUT cycles without io_ack, completing with cpu_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_bridge
    import io_bridge_pkg::*;
#(
    parameter int                DATA_W    = c_def_data_w,
    parameter int                ADDR_W    = c_def_addr_w,
    parameter int                PORT_AW   = c_def_port_aw,
    parameter logic [ADDR_W-1:0] IO_BASE   = c_def_io_base,
    parameter int                SETUP_CYC = c_def_setup_cyc,
    parameter int                TIMEOUT   = c_def_timeout
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic               cpu_write,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_err,
    inout  wire  [DATA_W-1:0]  io_data,
    output logic [PORT_AW-1:0] io_addr,
    output logic               io_oe,
    output logic               io_we,
    output logic               io_re,
    input  logic               io_ack
);

    localparam int                   c_setup_w    = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [c_setup_w-1:0] c_setup_last = c_setup_w'(SETUP_CYC - 1);

    // Reject configurations the datapath cannot support
    generate
        if (DATA_W < 8 || PORT_AW >= ADDR_W || SETUP_CYC < 1 || TIMEOUT < 1) begin : g_param_check
            $error("io_bus_bridge: illegal parameter combination");
        end
    endgenerate

    bridge_state_t        r_state;
    logic [c_setup_w-1:0] r_setup_cnt;
    logic                 r_write;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata;
    logic [PORT_AW-1:0]   r_io_addr;
    logic                 r_oe;
    logic                 r_we;
    logic                 r_re;
    logic                 r_ready;
    logic                 w_hit;

    // Only the window bits above the port field are decoded
    assign w_hit = cpu_req && (cpu_addr[ADDR_W-1:PORT_AW] == IO_BASE[ADDR_W-1:PORT_AW]);

`ifdef IO_BRIDGE_TIMEOUT_EN
    logic w_expire;
    logic r_err;

    io_timeout_counter #(
        .LIMIT  (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (reset),
        .load   (r_state != STROBE),
        .count  (r_state == STROBE),
        .expire (w_expire)
    );

    assign cpu_err = r_err;
`else
    assign cpu_err = 1'b0;
`endif

    // Transaction FSM with registered bus and CPU-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_setup_cnt <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_io_addr   <= '0;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_ready     <= 1'b0;
`ifdef IO_BRIDGE_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
        end else begin
            // Completion flags are single-cycle pulses
            r_ready <= 1'b0;
`ifdef IO_BRIDGE_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_state     <= SETUP;
                        r_setup_cnt <= '0;
                        r_write     <= cpu_write;
                        r_wdata     <= cpu_wdata;
                        r_io_addr   <= cpu_addr[PORT_AW-1:0];
                        // Writes drive the bus from the first setup cycle
                        r_oe        <= cpu_write;
                    end
                end
                SETUP: begin
                    if (r_setup_cnt == c_setup_last) begin
                        r_state <= STROBE;
                        r_we    <= r_write;
                        r_re    <= !r_write;
                    end else begin
                        r_setup_cnt <= r_setup_cnt + c_setup_w'(1);
                    end
                end
                STROBE: begin
                    if (io_ack) begin
                        r_state <= DONE;
                        r_oe    <= 1'b0;
                        r_we    <= 1'b0;
                        r_re    <= 1'b0;
                        r_ready <= 1'b1;
                        if (!r_write) begin
                            r_rdata <= io_data;
                        end
                    end
`ifdef IO_BRIDGE_TIMEOUT_EN
                    else if (w_expire) begin
                        r_state <= DONE;
                        r_oe    <= 1'b0;
                        r_we    <= 1'b0;
                        r_re    <= 1'b0;
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                        if (!r_write) begin
                            r_rdata <= '1;
                        end
                    end
`endif
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_io_addr <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_rdata;
    assign cpu_ready = r_ready;
    assign io_addr   = r_io_addr;
    assign io_oe     = r_oe;
    assign io_we     = r_we;
    assign io_re     = r_re;
    assign io_data   = r_oe ? r_wdata : {DATA_W{1'bz}};

endmodule : io_bus_bridge
`default_nettype wire
